operand2_pipe_shifter: RTL and testbench
========================================

# operand2_pipe_shifter

Pipelined, parametrised operand-2 generator for the execute stage. It accepts one data-processing or memory instruction's shifter fields per handshake and produces the second ALU operand plus the shifter carry-out. It covers the full ARM shifter set:
- rotated immediate;
- immediate shift, including the #0 special encodings;
- register-specified shift (by the `Rs` value);
- memory-offset pass-through.

A valid/ready pipeline of 1 or 2 register stages sits between the register-file read stage and the ALU.

## Interface
Parameters:
- `DATA_W`, 32: operand width; legal values 32 or 64.
- `LATENCY`, 1: register stages, 1 or 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input transaction present.
- `in_ready` output 1: block accepts an input this cycle.
- `mem_cmd` input 1: memory instruction; operand is the 12-bit offset.
- `imm` input 1: immediate operand (I bit).
- `shift_operand` input 12: instruction bits [11:0].
- `val_rm` input `DATA_W`: `Rm` value.
- `val_rs` input `DATA_W`: `Rs` value; used only for register shift.
- `carry_in` input 1: current CPSR C flag.
- `out_valid` output 1: result present.
- `out_ready` input 1: consumer accepts the result.
- `val_2` output `DATA_W`: second operand.
- `carry_out` output 1: shifter carry-out.

## Operation
Mode priority: `mem_cmd`, then `imm`, then `shift_operand[4]`. `n` is the shift amount.

- **mem_cmd = 1:** `val_2` = zero-extended `shift_operand[11:0]`; C = `carry_in`.
- **imm = 1:**
  - `val_2` = zero-extended `shift_operand[7:0]` rotated right by `2*shift_operand[11:8]`.
  - C = `carry_in` if the rotate amount is 0, else `val_2[DATA_W-1]`.
- **Immediate shift** (`shift_operand[4]` = 0): `n = shift_operand[11:7]`, type = `shift_operand[6:5]` (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - LSL #0: `Rm`, C = `carry_in`.
  - LSR #0: treated as LSR #32.
  - ASR #0: treated as ASR #32.
  - ROR #0: RRX, `{carry_in, Rm[DATA_W-1:1]}`, C = `Rm[0]`.
- **Register shift** (`shift_operand[4]` = 1): `n = val_rs[7:0]`, unsigned.
  - `n` = 0, any type: `Rm`, C = `carry_in`.
- **General shift results:**
  - LSL, `0 < n < DATA_W`: `Rm << n`, C = `Rm[DATA_W-n]`.
  - LSL, `n = DATA_W`: 0, C = `Rm[0]`.
  - LSL, `n > DATA_W`: 0, C = 0.
  - LSR, `0 < n < DATA_W`: `Rm >> n`, C = `Rm[n-1]`.
  - LSR, `n = DATA_W`: 0, C = `Rm[DATA_W-1]`.
  - LSR, `n > DATA_W`: 0, C = 0.
  - ASR, `0 < n < DATA_W`: arithmetic right shift, C = `Rm[n-1]`.
  - ASR, `n >= DATA_W`: all bits = `Rm[DATA_W-1]`, C = `Rm[DATA_W-1]`.
  - ROR with `n mod DATA_W` = 0 (and `n` ≠ 0): `Rm`, C = `Rm[DATA_W-1]`.
  - ROR otherwise: rotate right by `n mod DATA_W`, C = MSB of the result.
- For DATA_W=32, immediate-shift `n` is at most 31 except the #0 encodings, so the `n >= DATA_W` cases arise only from register shift or the encoded #32.

## Timing
- **Reset:** on `rst`, all stage valids clear.
  - Next cycle: `out_valid`=0, `val_2`=0, `carry_out`=0, `in_ready`=1.
  - Reset mid-operation discards in-flight transactions, with no partial output.
- **Handshake:** transfer occurs when `valid && ready` on a rising edge.
  - Stage k loads when it is empty or its downstream transfers this cycle.
  - `in_ready = !v_first || ready_into_second`, chained; the backward ready path is combinational.
- **Latency:** a transaction accepted at edge t is visible at the outputs after edge t+LATENCY-1 (LATENCY=1: registered output the cycle after acceptance). Full throughput is one per cycle.
- **LATENCY=2 stage split:**
  - Stage 1 registers the decoded kind, clipped amount, special-case flags, `Rm` and `carry_in`.
  - Stage 2 registers the shift result.
- **Stall:** while `out_valid && !out_ready`, `val_2` and `carry_out` hold stable and `in_ready` falls once all stages are full.
- **Ordering:** in order; no loss or duplication.
- **Simultaneous events:** `rst` dominates a simultaneous handshake.

## Structure
- Package `shifter_pkg`:
  - shift-type enum (`SH_LSL`/`SH_LSR`/`SH_ASR`/`SH_ROR`);
  - decoded-op struct (kind, amount, `rrx`, `zero_amt`, `ge_w`, `eq_w` flags);
  - mode enum (`MEM`, `IMM`, `SHIFT_IMM`, `SHIFT_REG`).
- Sub-module `shift_decode`: combinational decode of the fields into the decoded-op struct.
- Top: pipeline registers, handshake and the barrel shifter.

## Test plan
1. **Rotated immediate, carry from MSB.** Stimulus: `imm`=1, `shift_operand`=12'h4FF, `carry_in`=0 → `val_2`=0xFF000000, `carry_out`=1.
2. **Memory-offset pass-through.** Stimulus: `mem_cmd`=1, `shift_operand`=12'hABC, `carry_in`=1 → `val_2`=0x00000ABC, `carry_out`=1.
3. **Immediate-shift #0 special encodings**, `Rm`=0x80000001:
   - `shift_operand`=12'h020 (LSR #32) → 0x00000000, C=1;
   - `shift_operand`=12'h040 (ASR #32) → 0xFFFFFFFF, C=1;
   - `Rm`=0x3, `carry_in`=1, `shift_operand`=12'h060 (RRX) → 0x80000001, C=1.
4. **Register LSL at and beyond width.** `shift_operand`=12'h210, `Rm`=0xFFFFFFFF:
   - `val_rs`=32 → 0, C=1;
   - `val_rs`=33 → 0, C=0;
   - `val_rs`=0, `carry_in`=0 → 0xFFFFFFFF, C=0.
5. **Backpressure, LATENCY=2.** Stimulus: 4 back-to-back inputs while `out_ready`=0 for 3 cycles.
   - `in_ready` drops after 2 acceptances.
   - Outputs stay stable during the stall.
   - All 4 results then emerge in order, one per cycle.
6. **Reset mid-stream.** Stimulus: `rst` asserted with both stages full.
   - Next cycle: `out_valid`=0, `val_2`=0, `in_ready`=1.
   - The first post-reset input appears after LATENCY cycles.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the operand-2 shifter: shift kinds, operand modes and the
// decoded-operation record that travels down the pipeline.
package shifter_pkg;

    // Width of the clipped shift amount (n mod DATA_W), wide enough for DATA_W = 64.
    localparam int AMT_W = 6;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef enum logic [1:0] {
        MEM,
        IMM,
        SHIFT_IMM,
        SHIFT_REG
    } mode_e;

    // Everything the barrel shifter needs besides the source value and carry.
    typedef struct packed {
        shift_e           kind;      // shift type applied to the source
        logic [AMT_W-1:0] amount;    // effective amount modulo DATA_W
        logic             rrx;       // rotate right extended through carry
        logic             zero_amt;  // effective amount is zero: pass through
        logic             ge_w;      // effective amount >= DATA_W
        logic             eq_w;      // effective amount == DATA_W
    } dec_op_t;

    // Operand source selection: memory offset beats immediate beats shift form.
    function automatic mode_e decode_mode(input logic mem_cmd, input logic imm,
                                          input logic reg_shift);
        if (mem_cmd)        return MEM;
        else if (imm)       return IMM;
        else if (reg_shift) return SHIFT_REG;
        else                return SHIFT_IMM;
    endfunction

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of the instruction shifter fields into a source value
// and a normalised shift operation (kind, clipped amount, special-case flags).
module shift_decode
    import shifter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              mem_cmd_i,
    input  logic              imm_i,
    input  logic [11:0]       shift_operand_i,
    input  logic [DATA_W-1:0] val_rm_i,
    input  logic [7:0]        rs_lo_i,
    output dec_op_t           op_o,
    output logic [DATA_W-1:0] src_o
);

    mode_e      mode;
    logic [7:0] n_eff;

    // Pick the source and effective amount, then derive the boundary flags.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        mode  = decode_mode(mem_cmd_i, imm_i, shift_operand_i[4]);
        op_o  = '0;
        src_o = val_rm_i;
        n_eff = '0;
        case (mode)
            MEM: begin
                // Zero amount makes the shifter pass the offset and carry_in through.
                src_o = DATA_W'(shift_operand_i);
            end
            IMM: begin
                src_o     = DATA_W'(shift_operand_i[7:0]);
                op_o.kind = SH_ROR;
                n_eff     = {3'b000, shift_operand_i[11:8], 1'b0};
            end
            SHIFT_IMM: begin
                op_o.kind = shift_e'(shift_operand_i[6:5]);
                n_eff     = {3'b000, shift_operand_i[11:7]};
                // The #0 encodings of LSR/ASR mean #32; ROR #0 means RRX.
                if (n_eff == 8'd0) begin
                    if (op_o.kind == SH_LSR || op_o.kind == SH_ASR) n_eff = 8'd32;
                    if (op_o.kind == SH_ROR)                        op_o.rrx = 1'b1;
                end
            end
            SHIFT_REG: begin
                op_o.kind = shift_e'(shift_operand_i[6:5]);
                n_eff     = rs_lo_i;
            end
            default: begin
                src_o = val_rm_i;
            end
        endcase
        op_o.zero_amt = (n_eff == 8'd0);
        op_o.eq_w     = (n_eff == 8'(DATA_W));
        op_o.ge_w     = (n_eff >= 8'(DATA_W));
        op_o.amount   = AMT_W'(n_eff & 8'(DATA_W - 1));
    end

endmodule

// File: rtl/operand2_pipe_shifter.sv
// Operand-2 generator: decode, barrel shifter and a 1- or 2-stage valid/ready
// pipeline producing the second ALU operand and the shifter carry-out.
module operand2_pipe_shifter
    import shifter_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_cmd,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val_2,
    output logic              carry_out
);

    dec_op_t           dec_op;
    logic [DATA_W-1:0] dec_src;
    logic [DATA_W:0]   out_d;       // {carry, value} entering the output stage
    logic [DATA_W:0]   out_q;
    logic              out_v_q;
    logic              last_in_valid;
    logic              last_ready;

    // Only the low byte of Rs is a shift amount; the rest is ignored by design.
    logic unused_rs_hi;
    assign unused_rs_hi = ^val_rs[DATA_W-1:8];

    shift_decode #(.DATA_W(DATA_W)) u_decode (
        .mem_cmd_i       (mem_cmd),
        .imm_i           (imm),
        .shift_operand_i (shift_operand),
        .val_rm_i        (val_rm),
        .rs_lo_i         (val_rs[7:0]),
        .op_o            (dec_op),
        .src_o           (dec_src)
    );

    // Barrel shifter; returns {carry_out, result}.
    function automatic logic [DATA_W:0] barrel(input dec_op_t op,
                                               input logic [DATA_W-1:0] src,
                                               input logic cin);
        logic [DATA_W-1:0]   res;
        logic                c;
        logic [DATA_W:0]     wide;
        logic [2*DATA_W-1:0] dbl;
        res  = src;
        c    = cin;
        wide = '0;
        dbl  = '0;
        if (op.rrx) begin
            res = {cin, src[DATA_W-1:1]};
            c   = src[0];
        end else if (!op.zero_amt) begin
            case (op.kind)
                SH_LSL: begin
                    if (op.ge_w) begin
                        res = '0;
                        c   = op.eq_w ? src[0] : 1'b0;
                    end else begin
                        // Extra top bit catches the last bit shifted out.
                        wide = {1'b0, src} << op.amount;
                        res  = wide[DATA_W-1:0];
                        c    = wide[DATA_W];
                    end
                end
                SH_LSR: begin
                    if (op.ge_w) begin
                        res = '0;
                        c   = op.eq_w ? src[DATA_W-1] : 1'b0;
                    end else begin
                        wide = {src, 1'b0} >> op.amount;
                        res  = wide[DATA_W:1];
                        c    = wide[0];
                    end
                end
                SH_ASR: begin
                    if (op.ge_w) begin
                        res = {DATA_W{src[DATA_W-1]}};
                        c   = src[DATA_W-1];
                    end else begin
                        wide = $signed({src, 1'b0}) >>> op.amount;
                        res  = wide[DATA_W:1];
                        c    = wide[0];
                    end
                end
                SH_ROR: begin
                    // Amount 0 here means a multiple of DATA_W: result is src, C its MSB.
                    dbl = {src, src} >> op.amount;
                    res = dbl[DATA_W-1:0];
                    c   = res[DATA_W-1];
                end
                default: begin
                    res = src;
                    c   = cin;
                end
            endcase
        end
        return {c, res};
    endfunction

    assign last_ready = !out_v_q || out_ready;

    if (LATENCY == 1) begin : g_lat1
        assign in_ready      = last_ready;
        assign last_in_valid = in_valid;
        assign out_d         = barrel(dec_op, dec_src, carry_in);
    end else begin : g_lat2
        dec_op_t           op_q;
        logic [DATA_W-1:0] src_q;
        logic              cin_q;
        logic              s1_v_q;

        assign in_ready      = !s1_v_q || last_ready;
        assign last_in_valid = s1_v_q;
        assign out_d         = barrel(op_q, src_q, cin_q);

        // Stage-1 occupancy: refills whenever it can move on or is empty.
        always_ff @(posedge clk) begin
            if (rst)           s1_v_q <= 1'b0;
            else if (in_ready) s1_v_q <= in_valid;
        end

        // Stage-1 payload: decoded op, source and carry captured on acceptance.
        // NOTE: payload has no reset; s1_v_q alone decides whether it means anything.
        always_ff @(posedge clk) begin
            if (in_valid && in_ready) begin
                op_q  <= dec_op;
                src_q <= dec_src;
                cin_q <= carry_in;
            end
        end
    end

    // Output stage: holds its result while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v_q <= 1'b0;
            out_q   <= '0;
        end else if (last_ready) begin
            out_v_q <= last_in_valid;
            if (last_in_valid) out_q <= out_d;
        end
    end

    assign out_valid          = out_v_q;
    assign {carry_out, val_2} = out_q;

endmodule

// File: tb/tb_operand2_pipe_shifter.sv
// Self-checking bench: a LATENCY=2 instance (with backpressure) and a LATENCY=1
// instance fed the same accepted transactions, each with its own scoreboard.
module tb_operand2_pipe_shifter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, mem_cmd, imm, carry_in, out_ready;
    logic [11:0]   shift_operand;
    logic [W-1:0]  val_rm, val_rs;
    logic          in_ready, out_valid, carry_out;
    logic [W-1:0]  val_2;
    logic          in_valid1, in_ready1, out_valid1, carry_out1;
    logic [W-1:0]  val_2_1;

    logic [W:0]    q2[$];
    logic [W:0]    q1[$];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    operand2_pipe_shifter #(.DATA_W(W), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_cmd(mem_cmd), .imm(imm), .shift_operand(shift_operand),
        .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .val_2(val_2), .carry_out(carry_out)
    );

    // The LATENCY=1 copy sees exactly the transactions the LATENCY=2 copy accepts.
    assign in_valid1 = in_valid && in_ready;

    operand2_pipe_shifter #(.DATA_W(W), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .mem_cmd(mem_cmd), .imm(imm), .shift_operand(shift_operand),
        .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in),
        .out_valid(out_valid1), .out_ready(1'b1),
        .val_2(val_2_1), .carry_out(carry_out1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model written directly from the shifter rules; returns {C, value}.
    function automatic logic [W:0] model(input logic m, input logic i, input logic [11:0] so,
                                         input logic [W-1:0] rm, input logic [W-1:0] rs,
                                         input logic cin);
        int         n, rot, mo;
        logic [W-1:0] v;
        logic [1:0] t;
        if (m) return {cin, 20'h0, so};
        if (i) begin
            rot = 2 * so[11:8];
            v   = {24'h0, so[7:0]};
            if (rot == 0) return {cin, v};
            v = (v >> rot) | (v << (W - rot));
            return {v[W-1], v};
        end
        t = so[6:5];
        if (so[4]) begin
            n = rs[7:0];
            if (n == 0) return {cin, rm};
        end else begin
            n = so[11:7];
            if (n == 0) begin
                if (t == 2'b00) return {cin, rm};
                if (t == 2'b11) return {rm[0], cin, rm[W-1:1]};
                n = 32;
            end
        end
        case (t)
            2'b00: begin
                if (n < W)  return {rm[W-n], rm << n};
                if (n == W) return {rm[0], {W{1'b0}}};
                return '0;
            end
            2'b01: begin
                if (n < W)  return {rm[n-1], rm >> n};
                if (n == W) return {rm[W-1], {W{1'b0}}};
                return '0;
            end
            2'b10: begin
                if (n < W) begin
                    v = $signed(rm) >>> n;
                    return {rm[n-1], v};
                end
                return {rm[W-1], {W{rm[W-1]}}};
            end
            default: begin
                mo = n % W;
                if (mo == 0) return {rm[W-1], rm};
                v = (rm >> mo) | (rm << (W - mo));
                return {v[W-1], v};
            end
        endcase
    endfunction

    // Drive one transaction (called just after a rising edge); expectation is
    // queued at the negedge where the handshake is seen to be ready.
    task automatic send(input logic m, input logic i, input logic [11:0] so,
                        input logic [W-1:0] rm, input logic [W-1:0] rs, input logic cin,
                        input logic [W:0] exp);
        int waited = 0;
        bit done   = 1'b0;
        mem_cmd = m; imm = i; shift_operand = so; val_rm = rm; val_rs = rs;
        carry_in = cin; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                q2.push_back(exp);
                q1.push_back(exp);
                done = 1'b1;
            end else if (++waited > 100) begin
                n_cmp++;
                n_err++;
                $error("FAIL send_timeout: in_ready stayed %0b for %0d cycles", in_ready, waited);
                in_valid = 1'b0;
                done     = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendm(input logic m, input logic i, input logic [11:0] so,
                         input logic [W-1:0] rm, input logic [W-1:0] rs, input logic cin);
        send(m, i, so, rm, rs, cin, model(m, i, so, rm, rs, cin));
    endtask

    task automatic drain();
        int k = 0;
        while ((q1.size() != 0 || q2.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        check("drain_empty", 64'(q1.size() + q2.size()), 64'd0);
    endtask

    // Scoreboard: pop and compare on every output handshake of each instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL l2_unexpected: observed %0h expected none", {carry_out, val_2});
                end else begin
                    check("l2_result", {carry_out, val_2}, q2.pop_front());
                end
            end
            if (out_valid1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL l1_unexpected: observed %0h expected none", {carry_out1, val_2_1});
                end else begin
                    check("l1_result", {carry_out1, val_2_1}, q1.pop_front());
                end
            end
            if (in_valid1) check("l1_in_ready", in_ready1, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W:0]   exp_a;
    logic [W-1:0] r_rm, r_rs;
    logic [11:0]  r_so;
    logic         r_m, r_i, r_c;
    bit           rand_done;

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_cmd = 1'b0; imm = 1'b0; carry_in = 1'b0;
        shift_operand = '0; val_rm = '0; val_rs = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_val_2", val_2, 0);
        check("reset_carry", carry_out, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid_l1", out_valid1, 0);
        @(posedge clk); #1;

        // Directed cases with hand-derived expectations
        send(0, 1, 12'h4FF, 32'h0,        32'h0,  0, {1'b1, 32'hFF000000});
        send(1, 0, 12'hABC, 32'h0,        32'h0,  1, {1'b1, 32'h00000ABC});
        send(0, 0, 12'h020, 32'h80000001, 32'h0,  0, {1'b1, 32'h00000000});
        send(0, 0, 12'h040, 32'h80000001, 32'h0,  0, {1'b1, 32'hFFFFFFFF});
        send(0, 0, 12'h060, 32'h00000003, 32'h0,  1, {1'b1, 32'h80000001});
        send(0, 0, 12'h210, 32'hFFFFFFFF, 32'd32, 0, {1'b1, 32'h00000000});
        send(0, 0, 12'h210, 32'hFFFFFFFF, 32'd33, 0, {1'b0, 32'h00000000});
        send(0, 0, 12'h210, 32'hFFFFFFFF, 32'd0,  0, {1'b0, 32'hFFFFFFFF});
        send(0, 0, 12'h200, 32'hF000000F, 32'h0,  0, {1'b1, 32'h000000F0});
        send(0, 0, 12'h270, 32'h80000000, 32'd32, 0, {1'b1, 32'h80000000});
        send(0, 0, 12'h250, 32'h7FFFFFFF, 32'd40, 1, {1'b0, 32'h00000000});
        send(0, 0, 12'h230, 32'h00000003, 32'd1,  0, {1'b1, 32'h00000001});
        drain();
        @(posedge clk); #1;

        // Backpressure on the two-stage pipeline
        exp_a = model(0, 1, 12'h1AB, 32'h0, 32'h0, 1);
        out_ready = 1'b0;
        fork
            begin
                sendm(0, 1, 12'h1AB, 32'h0,        32'h0,  1);
                sendm(0, 0, 12'h370, 32'h12345678, 32'd8,  0);
                sendm(0, 0, 12'h240, 32'h80000010, 32'h0,  1);
                sendm(1, 0, 12'h123, 32'hDEADBEEF, 32'h5,  0);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_first_out", {carry_out, val_2}, exp_a);
                @(negedge clk);
                check("bp_hold", {carry_out, val_2}, exp_a);
                check("bp_in_ready_still_low", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_stream_valid", out_valid, 1);
                end
            end
        join
        drain();
        @(posedge clk); #1;

        // Reset with both stages occupied
        out_ready = 1'b0;
        sendm(0, 0, 12'h0A0, 32'h0000FF00, 32'h0, 0);
        sendm(0, 1, 12'h3C3, 32'h0,        32'h0, 0);
        check("rst_pre_full", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q1.delete();
        q2.delete();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_val_2", val_2, 0);
        check("rst_carry", carry_out, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_l1", out_valid1, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        sendm(0, 0, 12'h0C0, 32'h80000000, 32'h0, 0);
        @(negedge clk);
        check("rst_lat_not_early", out_valid, 0);
        @(negedge clk);
        check("rst_lat_visible", out_valid, 1);
        drain();
        @(posedge clk); #1;

        // Mixed random traffic with random consumer stalls
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    r_rm = $urandom;
                    case ($urandom_range(0, 6))
                        0:       r_rs = 32'd0;
                        1:       r_rs = 32'd1;
                        2:       r_rs = 32'd31;
                        3:       r_rs = 32'd32;
                        4:       r_rs = 32'd33;
                        5:       r_rs = 32'd255;
                        default: r_rs = $urandom;
                    endcase
                    r_so = 12'($urandom);
                    r_m  = ($urandom_range(0, 7) == 0);
                    r_i  = ($urandom_range(0, 3) == 0);
                    r_c  = 1'($urandom_range(0, 1));
                    sendm(r_m, r_i, r_so, r_rm, r_rs, r_c);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
